// File: rtl/mod_alu_seq_if.sv
// ============================================================================
// Module   : mod_alu_seq_if
// Purpose  : Request/result handshake bundle for the sequential modular ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mod_alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, r, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, r, err
  );
endinterface

`default_nettype wire

// File: rtl/mod_alu_seq.sv
// ============================================================================
// Module   : mod_alu_seq
// Purpose  : Sequential mod-P ALU: ADD/SUB in one cycle, MUL bit-serial,
//            INV by binary extended Euclid.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mod_alu_seq #(
  parameter int          WIDTH = 8,
  parameter int unsigned P     = 251
) (
  input  wire logic  clk,
  input  wire logic  rst,
  mod_alu_seq_if.slave bus
);

  localparam logic [WIDTH:0]   P_X   = (WIDTH+1)'(P);
  localparam logic [WIDTH-1:0] P_W   = WIDTH'(P);
  localparam int               CNT_W = $clog2(2*WIDTH+1);
  localparam logic [1:0]       OP_ADD = 2'b00;
  localparam logic [1:0]       OP_SUB = 2'b01;
  localparam logic [1:0]       OP_MUL = 2'b10;
  localparam logic [1:0]       OP_INV = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH-1:0]   u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bad_q, bad_d, err_q, err_d;
  logic [WIDTH-1:0]   mul_step;

  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= P_X) s = s - P_X;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[WIDTH]) d = d + P_X;
    return d[WIDTH-1:0];
  endfunction

  // x/2 mod P: an odd x is made even by adding the odd modulus first
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] t;
    t = {1'b0, x} + (x[0] ? P_X : '0);
    return t[WIDTH:1];
  endfunction

  assign mul_step = a_q[WIDTH-1] ? add_mod(add_mod(acc_q, acc_q), b_q)
                                 : add_mod(acc_q, acc_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = CALC;
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          bad_d   = (bus.a >= P_W) || ((bus.op != OP_INV) && (bus.b >= P_W)) ||
                    ((bus.op == OP_INV) && (bus.a == '0));
          acc_d   = '0;
          u_d     = bus.a;
          v_d     = P_W;
          x1_d    = WIDTH'(1);
          x2_d    = '0;
          cnt_d   = '0;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        err_d = 1'b0;
        if (bad_q) begin
          r_d     = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          case (op_q)
            OP_ADD: begin
              r_d     = add_mod(a_q, b_q);
              state_d = DONE;
            end
            OP_SUB: begin
              r_d     = sub_mod(a_q, b_q);
              state_d = DONE;
            end
            OP_MUL: begin
              acc_d = mul_step;
              a_d   = a_q << 1;
              if (cnt_q == CNT_W'(WIDTH-1)) begin
                r_d     = mul_step;
                state_d = DONE;
              end
            end
            default: begin
              // A subtraction always leaves an even value, so it is halved in
              // the same cycle; u*v then at least halves every step.
              if (u_q == WIDTH'(1)) begin
                r_d     = x1_q;
                state_d = DONE;
              end else if (v_q == WIDTH'(1)) begin
                r_d     = x2_q;
                state_d = DONE;
              end else if (!u_q[0]) begin
                u_d  = u_q >> 1;
                x1_d = half_mod(x1_q);
              end else if (!v_q[0]) begin
                v_d  = v_q >> 1;
                x2_d = half_mod(x2_q);
              end else if (u_q > v_q) begin
                u_d  = (u_q - v_q) >> 1;
                x1_d = half_mod(sub_mod(x1_q, x2_q));
              end else begin
                v_d  = (v_q - u_q) >> 1;
                x2_d = half_mod(sub_mod(x2_q, x1_q));
              end
            end
          endcase
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.r         = r_q;
  assign bus.err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_alu_seq.sv
// ============================================================================
// Module   : tb_mod_alu_seq
// Purpose  : Random and directed checks of mod_alu_seq against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mod_alu_seq;
  localparam int W  = 8;
  localparam int PM = 251;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  mod_alu_seq_if #(.WIDTH(W)) bus ();
  mod_alu_seq #(.WIDTH(W), .P(PM)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Plain-arithmetic reference: residues by %, inverse by exhaustive search
  task automatic ref_model(input int op, input int a, input int b,
                           output int r, output int e);
    r = 0;
    e = 0;
    if (a >= PM || (op != 3 && b >= PM) || (op == 3 && a == 0)) begin
      e = 1;
    end else begin
      case (op)
        0: r = (a + b) % PM;
        1: r = (a + PM - b) % PM;
        2: r = (a * b) % PM;
        default: for (int x = 1; x < PM; x++) if ((a * x) % PM == 1) r = x;
      endcase
    end
  endtask

  task automatic junk_inputs();
    bus.op = 2'($urandom);
    bus.a  = 8'($urandom);
    bus.b  = 8'($urandom);
  endtask

  task automatic do_op(input int op, input int a, input int b, input int hold, input int exp_n);
    int er, ee, n, waited;
    ref_model(op, a, b, er, ee);
    @(negedge clk);
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.op        = 2'(op);
    bus.a         = 8'(a);
    bus.b         = 8'(b);
    bus.out_ready = (hold == 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    junk_inputs();
    n = 0;
    while (n < 40) begin
      n++;
      if (bus.out_valid) break;
      @(posedge clk);
      #1;
      junk_inputs();
    end
    // loop counts the accept-edge sample as 1, so latency = n-1 edges after it
    n = n - 1;
    chk("out_valid", 32'(bus.out_valid), 1);
    chk("r", 32'(bus.r), 32'(er));
    chk("err", 32'(bus.err), 32'(ee));
    if (exp_n > 0) chk("latency", 32'(n), 32'(exp_n));
    else           chk("inv_latency_bound", 32'(n >= 1 && n <= 2*W), 1);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      junk_inputs();
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_r", 32'(bus.r), 32'(er));
      chk("hold_err", 32'(bus.err), 32'(ee));
      chk("hold_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_valid", 32'(bus.out_valid), 0);
    chk("release_in_ready", 32'(bus.in_ready), 1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int op, a, b, en;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    bus.op        = 2'b00;
    bus.a         = 8'd1;
    bus.b         = 8'd1;
    rst           = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_r", 32'(bus.r), 0);
      chk("rst_err", 32'(bus.err), 0);
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(bus.in_ready), 1);

    do_op(0, 250, 3, 0, 1);
    do_op(1, 3, 5, 1, 1);
    do_op(2, 200, 200, 2, W);
    do_op(2, 0, 77, 0, W);
    do_op(2, 250, 250, 0, W);
    do_op(3, 2, 0, 0, 0);
    do_op(3, 1, 0, 0, 1);
    do_op(3, 250, 0, 1, 0);
    do_op(3, 0, 0, 0, 1);
    do_op(0, 251, 1, 0, 1);
    do_op(1, 5, 255, 0, 1);
    do_op(0, 250, 250, 0, 1);
    do_op(2, 123, 45, 10, W);

    // reset lands on the 4th CALC edge of a multiply
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 2'b10;
    bus.a        = 8'd200;
    bus.b        = 8'd200;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_in_ready", 32'(bus.in_ready), 1);
    do_op(0, 1, 1, 0, 1);

    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 3));
      a  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, PM-1));
      b  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, PM-1));
      if (a >= PM || (op != 3 && b >= PM) || (op == 3 && a == 0)) en = 1;
      else if (op == 2) en = W;
      else if (op == 3) en = (a == 1) ? 1 : 0;
      else en = 1;
      do_op(op, a, b, int'($urandom_range(0, 3)), en);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/mod_alu_seq.md
MOD_ALU_SEQ -- requirements
Module: mod_alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits; legal range 4..256.
REQ-002 The block SHALL have parameter P, default 251: odd prime modulus; legal range 3 <= P < 2^WIDTH; other values are out of contract.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: an operation request is present.
REQ-006 Port in_ready, output, 1 bit: the block can accept a request.
REQ-007 Port op, input, 2 bits: operation select; 00 ADD, 01 SUB, 10 MUL, 11 INV.
REQ-008 Port a, input, WIDTH bits: first operand; the only operand for INV.
REQ-009 Port b, input, WIDTH bits: second operand; ignored for INV.
REQ-010 Port out_valid, output, 1 bit: result is present.
REQ-011 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 Port r, output, WIDTH bits: result in [0, P-1].
REQ-013 Port err, output, 1 bit: result is invalid (operand >= P, or INV of 0); valid only while out_valid is high.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, CALC and DONE; in_ready SHALL equal (state==IDLE).
REQ-015 A request SHALL be accepted on the edge where in_valid && in_ready; op, a and b are captured, and the FSM goes IDLE->CALC.
REQ-016 If the accepting edge is k, out_valid SHALL rise at edge k+N and the FSM SHALL be in DONE.
- ADD, SUB: N=1.
- MUL: N=WIDTH.
- INV: N data-dependent, 1 <= N <= 2*WIDTH.
- Error cases: N=1.
REQ-017 In DONE, r and err SHALL hold stable until out_valid && out_ready; on that edge the FSM SHALL go to IDLE and out_valid SHALL fall.
REQ-018 While the FSM is in CALC or DONE, input changes SHALL have no effect, and no request is accepted; in_valid/in_ready handshakes never overlap.
REQ-019 ADD SHALL produce (a+b) mod P, using an internal WIDTH+1-bit sum and a single conditional subtraction of P.
REQ-020 SUB SHALL produce (a-b) mod P, using a WIDTH+1-bit difference and a conditional addition of P when the borrow bit is set.
REQ-021 MUL SHALL produce (a*b) mod P by MSB-first double-and-add, one bit of a per CALC cycle. Each cycle:
- acc = (2*acc) mod P;
- if a bit is set, acc = (acc+b) mod P;
- every intermediate value is kept in [0, P-1] with at most WIDTH+1 bits.
REQ-022 INV SHALL produce a^-1 mod P by binary extended Euclid with u=a, v=P, x1=1, x2=0.
- Each cycle performs one reduction step: halve an even u or v (adjusting x1/x2 by +P when odd before halving), else subtract the smaller of u/v from the larger.
- Termination: when u==1 (r=x1) or v==1 (r=x2).
- The FSM SHALL enter DONE no later than 2*WIDTH cycles after acceptance.
REQ-023 If a >= P, or (op != INV and b >= P), or (op==INV and a==0), the block SHALL return r=0, err=1 with N=1.
REQ-024 Otherwise err SHALL be 0.
REQ-025 Boundary operands SHALL be handled without special cases:
- a=0 or b=0 for MUL gives 0;
- a=1 for INV gives 1 with N=1 (termination is checked before the first step);
- a=P-1, b=P-1 for ADD gives P-2.
REQ-026 When in DONE with out_ready already high, out_valid SHALL still be high for at least one cycle.

Reset
REQ-027 While rst=1 at an edge, the FSM SHALL go to IDLE and outputs SHALL be: in_ready=1 after reset, out_valid=0, r=0, err=0.
REQ-028 Reset SHALL abort any operation in CALC or DONE without producing a result; the first request after reset SHALL behave identically to one issued after power-up.
REQ-029 in_valid asserted in the same cycle as rst=1 SHALL NOT be accepted.

Verification (WIDTH=8, P=251)
REQ-030 ADD a=250, b=3 -> r=2, err=0, out_valid one edge after accept; SUB a=3, b=5 -> r=249.
REQ-031 MUL a=200, b=200 -> r=91, out_valid exactly 8 edges after accept; MUL a=0, b=77 -> r=0.
REQ-032 INV a=2 -> r=126 within 16 cycles; INV a=1 -> r=1 at N=1; INV a=250 -> r=250; INV a=0 -> r=0, err=1.
REQ-033 ADD a=251, b=1 -> r=0, err=1, N=1.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles after a MUL result.
- r, err and out_valid stay stable;
- in_ready stays 0;
- a second in_valid is ignored until the result handshake completes.
REQ-035 Assert rst at the 4th CALC cycle of a MUL -> next edge out_valid=0, in_ready=1; a following ADD 1+1 -> r=2.
